// File: rtl/apb_add_master.sv
// APB requester: one add command -> write A, write B, compute/read; 1-cycle result strobe.
// Latency SETUP+ACCESS per transfer (9 edges vs registered-PREADY responder); cmd_ready only in IDLE.
module apb_add_master #(
  parameter logic [31:0] ADDR_A  = 32'h0000_0000,
  parameter logic [31:0] ADDR_B  = 32'h0000_0004,
  parameter logic [31:0] ADDR_S  = 32'h0000_0008,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PRWADDR,
  output logic [31:0] PRWDATA,
  output logic [1:0]  f,
  input  logic [31:0] PRDATA1,
  input  logic        PREADY
);

  typedef enum logic [2:0] {
    IDLE, SETUP_A, ACCESS_A, SETUP_B, ACCESS_B, SETUP_S, ACCESS_S, DONE
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [7:0]  wait_q;
  logic        hs;
  logic        timeout;
  logic        in_access;

  logic        psel_d, penable_d, pwrite_d, res_valid_d, cmd_ready_d;
  logic [31:0] addr_d, wdata_d;
  logic [1:0]  f_d;

  assign hs        = (state_q == IDLE) && cmd_valid && cmd_ready;
  assign in_access = (state_q == ACCESS_A) || (state_q == ACCESS_B) || (state_q == ACCESS_S);

  // Next-state logic; a stalled ACCESS aborts straight to DONE on the TIMEOUT-th wait edge.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE:     if (hs) state_d = SETUP_A;
      SETUP_A:  state_d = ACCESS_A;
      ACCESS_A: begin
        if (PREADY) state_d = SETUP_B;
        else if (wait_q == WAIT_LAST) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      SETUP_B:  state_d = ACCESS_B;
      ACCESS_B: begin
        if (PREADY) state_d = SETUP_S;
        else if (wait_q == WAIT_LAST) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      SETUP_S:  state_d = ACCESS_S;
      ACCESS_S: begin
        if (PREADY) state_d = DONE;
        else if (wait_q == WAIT_LAST) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so nothing from PREADY reaches a pin.
  always_comb begin
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    f_d         = 2'b00;
    res_valid_d = 1'b0;
    cmd_ready_d = 1'b0;
    case (state_d)
      IDLE: cmd_ready_d = 1'b1;
      SETUP_A, ACCESS_A: begin
        psel_d    = 1'b1;
        penable_d = (state_d == ACCESS_A);
        pwrite_d  = 1'b1;
        f_d       = 2'b01;
        addr_d    = ADDR_A;
        wdata_d   = hs ? cmd_a : a_q;
      end
      SETUP_B, ACCESS_B: begin
        psel_d    = 1'b1;
        penable_d = (state_d == ACCESS_B);
        pwrite_d  = 1'b1;
        f_d       = 2'b10;
        addr_d    = ADDR_B;
        wdata_d   = b_q;
      end
      SETUP_S, ACCESS_S: begin
        psel_d    = 1'b1;
        penable_d = (state_d == ACCESS_S);
        f_d       = 2'b11;
        addr_d    = ADDR_S;
      end
      DONE: res_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      wait_q    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PRWADDR   <= '0;
      PRWDATA   <= '0;
      f         <= 2'b00;
      res_valid <= 1'b0;
      cmd_ready <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PRWADDR   <= addr_d;
      PRWDATA   <= wdata_d;
      f         <= f_d;
      res_valid <= res_valid_d;
      cmd_ready <= cmd_ready_d;
      if (hs) begin
        a_q <= cmd_a;
        b_q <= cmd_b;
      end
      // Every ACCESS is entered from its SETUP, so clearing there restarts the wait count.
      if (!in_access) wait_q <= '0;
      else if (!PREADY) wait_q <= wait_q + 8'd1;
      // Result registers change only on entry to DONE and otherwise hold.
      if (state_q == ACCESS_S && PREADY) begin
        res_data <= PRDATA1;
        res_err  <= 1'b0;
      end else if (timeout) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end
    end
  end

endmodule
